// File: rtl/loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;
  localparam int LEN_W      = 8 * LEN_BYTES;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam state_t S_TAIL = S_DONE;
`endif

  function automatic logic accepts(state_t s);
    return !(s inside {S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = loader.
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Packs bytes little-endian into 32-bit words.
// word_valid pulses the cycle after the 4th byte of a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [31:0] sr;

  assign last_byte = (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (byte_valid) begin
        // shift right so the first byte lands in [7:0]
        sr  <= {byte_data, sr[31:8]};
        cnt <= cnt + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {byte_data, sr[31:8]};
        end
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: length-prefixed byte image -> sequential imem writes.
// Build option: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  inst_mem_loader_if.slave   bus,
  output logic               core_rst,
  output logic               load_done,
  output logic               load_err
);

  localparam int          CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned CAP_N = 2 ** ADDR_WIDTH;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              len_lo;
  logic [LEN_W-1:0]        len_full;
  logic [CNT_W-1:0]        n_words;
  logic [CNT_W-1:0]        word_cnt;
  logic [CNT_W-1:0]        word_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    fire;
  logic                    pk_last;
  logic                    pk_valid;
  logic [31:0]             pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  assign fire     = bus.rx_valid && bus.rx_ready;
  assign len_full = {bus.rx_data, len_lo};
  assign word_nxt = word_cnt + CNT_W'(1);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (state != S_DATA),
    .byte_valid (fire && (state == S_DATA)),
    .byte_data  (bus.rx_data),
    .last_byte  (pk_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  assign bus.mem_we    = pk_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = DATA_WIDTH'(pk_word);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LEN0: begin
        if (fire) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        if (fire) begin
          if (32'(len_full) > CAP_N) state_nxt = S_ERR;
          else if (len_full == '0)   state_nxt = S_TAIL;
          else                       state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (fire && pk_last && (word_nxt == n_words))
          state_nxt = S_TAIL;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (fire)
          state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_LEN0;
      bus.rx_ready <= 1'b0;
      len_lo       <= '0;
      n_words      <= '0;
      word_cnt     <= '0;
      addr_q       <= '0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state        <= state_nxt;
      bus.rx_ready <= accepts(state_nxt);
      if (fire && (state == S_LEN0))
        len_lo <= bus.rx_data;
      if (fire && (state == S_LEN1))
        n_words <= CNT_W'(len_full);
      // address is latched with the 4th byte so it lines up with mem_we
      if (fire && (state == S_DATA) && pk_last) begin
        addr_q   <= word_cnt[ADDR_WIDTH-1:0];
        word_cnt <= word_nxt;
      end
      if (state == S_DONE) begin
        load_done <= 1'b1;
        core_rst  <= 1'b0;
      end
      if (state == S_ERR)
        load_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (fire)
        csum <= csum ^ bus.rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader with a queue-based image model.
// Honours LOADER_CHECKSUM_EN to append/verify the checksum byte.
module tb_inst_mem_loader;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst;
  logic load_done;
  logic load_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+31:0] cap_q[$];
  logic [31:0]    img_w[$];
  logic [7:0]     img_b[$];

  inst_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.mem_we === 1'b1)
      cap_q.push_back({bus.mem_addr, bus.mem_wdata});

  // image = LE 16-bit word count, LE words, optional XOR of all prior bytes
  task automatic make_bytes();
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(img_w.size());
    img_b.delete();
    img_b.push_back(n[7:0]);
    img_b.push_back(n[15:8]);
    foreach (img_w[i])
      for (int k = 0; k < 4; k++)
        img_b.push_back(8'(img_w[i] >> (8 * k)));
    x = 8'h00;
    foreach (img_b[i]) x = x ^ img_b[i];
`ifdef LOADER_CHECKSUM_EN
    img_b.push_back(x);
`endif
  endtask

  task automatic make_random(input int n);
    img_w.delete();
    for (int i = 0; i < n; i++) img_w.push_back($urandom);
    make_bytes();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte timeout: rx_ready stayed %b, need 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_image(input int gap_max);
    foreach (img_b[i]) begin
      send_byte(img_b[i]);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(load_done || load_err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: done=%b err=%b, need one set", name, load_done, load_err);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cap_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 7;
    if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b need 0", bus.rx_ready); end
    if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b need 0", bus.mem_we); end
    if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL rst_addr got %h need 0", bus.mem_addr); end
    if (bus.mem_wdata !== '0) begin n_bad++; $display("FAIL rst_wdata got %h need 0", bus.mem_wdata); end
    if (core_rst !== 1'b1) begin n_bad++; $display("FAIL rst_core got %b need 1", core_rst); end
    if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b need 0", load_done); end
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b need 0", load_err); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b need 1", bus.rx_ready); end
  endtask

  task automatic test_two_words();
    do_reset();
    img_w = '{32'h0000_0013, 32'h0000_006F};
    make_bytes();
    for (int i = 0; i < 6; i++) send_byte(img_b[i]);
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd0) begin
      n_bad++; $display("FAIL w0_pulse got we=%b addr=%h need we=1 addr=00", bus.mem_we, bus.mem_addr);
    end
    for (int i = 6; i < img_b.size(); i++) send_byte(img_b[i]);
`ifndef LOADER_CHECKSUM_EN
    n_cmp++;
    if (bus.mem_we !== 1'b1 || load_done !== 1'b0) begin
      n_bad++; $display("FAIL last_pulse got we=%b done=%b need we=1 done=0", bus.mem_we, load_done);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done !== 1'b1 || core_rst !== 1'b0) begin
      n_bad++; $display("FAIL done_timing got done=%b core_rst=%b need 1/0", load_done, core_rst);
    end
`endif
    wait_end("two_words");
    n_cmp += 2;
    if (cap_q.size() !== 2) begin n_bad++; $display("FAIL two_cnt got %0d need 2", cap_q.size()); end
    if (cap_q.size() == 2 && (cap_q[0] !== 40'h00_0000_0013 || cap_q[1] !== 40'h01_0000_006F)) begin
      n_bad++; $display("FAIL two_data got %h %h need 0000000013 010000006f", cap_q[0], cap_q[1]);
    end
    n_cmp++;
    if (load_done !== 1'b1 || core_rst !== 1'b0 || load_err !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_bad++; $display("FAIL two_status got done=%b crst=%b err=%b rdy=%b need 1/0/0/0",
                        load_done, core_rst, load_err, bus.rx_ready);
    end
    // stream after done must be ignored
    bus.rx_valid = 1'b1;
    repeat (8) begin bus.rx_data = 8'($urandom); @(negedge clk); end
    bus.rx_valid = 1'b0;
    n_cmp++;
    if (cap_q.size() !== 2 || load_done !== 1'b1 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL after_done got writes=%0d done=%b err=%b need 2/1/0",
                        cap_q.size(), load_done, load_err);
    end
  endtask

  task automatic test_zero_len();
    int n = 0;
    do_reset();
    img_w.delete();
    make_bytes();
    send_image(0);
    while (load_done !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    n_cmp += 2;
    if (load_done !== 1'b1 || core_rst !== 1'b0) begin
      n_bad++; $display("FAIL zero_done got done=%b crst=%b need 1/0", load_done, core_rst);
    end
`ifndef LOADER_CHECKSUM_EN
    if (n > 1) begin n_bad++; $display("FAIL zero_latency got %0d need <=1 extra cycles", n); end
`else
    n_cmp--;
`endif
    n_cmp++;
    if (cap_q.size() !== 0) begin n_bad++; $display("FAIL zero_writes got %0d need 0", cap_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    wait_end("overflow");
    n_cmp++;
    if (load_err !== 1'b1 || core_rst !== 1'b1 || bus.rx_ready !== 1'b0 || load_done !== 1'b0) begin
      n_bad++; $display("FAIL ovf_status got err=%b crst=%b rdy=%b done=%b need 1/1/0/0",
                        load_err, core_rst, bus.rx_ready, load_done);
    end
    n_cmp++;
    if (cap_q.size() !== 0) begin n_bad++; $display("FAIL ovf_writes got %0d need 0", cap_q.size()); end
  endtask

  task automatic test_full_capacity();
    do_reset();
    make_random(2 ** AW);
    send_image(0);
    wait_end("full");
    n_cmp++;
    if (cap_q.size() !== 2 ** AW) begin n_bad++; $display("FAIL full_cnt got %0d need %0d", cap_q.size(), 2 ** AW); end
    foreach (img_w[i]) if (i < cap_q.size()) begin
      n_cmp++;
      if (cap_q[i] !== {AW'(i), img_w[i]}) begin
        n_bad++; $display("FAIL full_w%0d got %h need %h", i, cap_q[i], {AW'(i), img_w[i]});
      end
    end
    n_cmp++;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL full_status got done=%b err=%b need 1/0", load_done, load_err);
    end
  endtask

  task automatic test_gaps();
    logic [AW+31:0] ref_q[$];
    do_reset();
    make_random(16);
    send_image(0);
    wait_end("nogap");
    ref_q = cap_q;
    do_reset();
    send_image(5);
    wait_end("gaps");
    n_cmp++;
    if (cap_q.size() !== 16 || ref_q.size() !== 16) begin
      n_bad++; $display("FAIL gap_cnt got %0d/%0d need 16/16", cap_q.size(), ref_q.size());
    end
    foreach (img_w[i]) if (i < cap_q.size() && i < ref_q.size()) begin
      n_cmp++;
      if (cap_q[i] !== {AW'(i), img_w[i]} || ref_q[i] !== cap_q[i]) begin
        n_bad++; $display("FAIL gap_w%0d got %h nogap %h need %h", i, cap_q[i], ref_q[i], {AW'(i), img_w[i]});
      end
    end
    n_cmp++;
    if (load_done !== 1'b1) begin n_bad++; $display("FAIL gap_done got %b need 1", load_done); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    make_random(16);
    for (int i = 0; i < 8; i++) send_byte(img_b[i]);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core_rst !== 1'b1 || bus.rx_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_hold got crst=%b rdy=%b need 1/0", core_rst, bus.rx_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    cap_q.delete();
    send_image(2);
    wait_end("midrst");
    n_cmp++;
    if (cap_q.size() !== 16) begin n_bad++; $display("FAIL midrst_cnt got %0d need 16", cap_q.size()); end
    foreach (img_w[i]) if (i < cap_q.size()) begin
      n_cmp++;
      if (cap_q[i] !== {AW'(i), img_w[i]}) begin
        n_bad++; $display("FAIL midrst_w%0d got %h need %h", i, cap_q[i], {AW'(i), img_w[i]});
      end
    end
    n_cmp++;
    if (load_done !== 1'b1 || core_rst !== 1'b0) begin
      n_bad++; $display("FAIL midrst_done got done=%b crst=%b need 1/0", load_done, core_rst);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] good[$];
    good = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    do_reset();
    foreach (good[i]) send_byte(good[i]);
    wait_end("csum_ok");
    n_cmp++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || core_rst !== 1'b0) begin
      n_bad++; $display("FAIL csum_ok got done=%b err=%b crst=%b need 1/0/0", load_done, load_err, core_rst);
    end
    good[6] = 8'h00;
    do_reset();
    foreach (good[i]) send_byte(good[i]);
    wait_end("csum_bad");
    n_cmp++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || core_rst !== 1'b1) begin
      n_bad++; $display("FAIL csum_bad got err=%b done=%b crst=%b need 1/0/1", load_err, load_done, core_rst);
    end
  endtask
`endif

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_two_words();
    test_zero_len();
    test_overflow();
    test_full_capacity();
    test_gaps();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
